// File: rtl/t_decode_pkg.sv
// Shared types and constants for the T-flop decode/check slice.
package t_decode_pkg;
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int unsigned SRC_D  = 0;
    localparam int unsigned SRC_SR = 1;
    localparam int unsigned SRC_JK = 2;
endpackage

// File: rtl/maj3_vote.sv
// Combinational 2-of-3 vote over the redundant T-flop outputs, with disagreement info.
module maj3_vote
    import t_decode_pkg::*;
(
    input  logic       i_d,
    input  logic       i_sr,
    input  logic       i_jk,
    output logic       o_maj,
    output logic       o_disagree,
    output logic [2:0] o_diff
);
    always_comb begin
        o_maj          = (i_d & i_sr) | (i_d & i_jk) | (i_sr & i_jk);
        o_disagree     = !((i_d == i_sr) && (i_sr == i_jk));
        o_diff         = '0;
        o_diff[SRC_D]  = i_d  ^ o_maj;
        o_diff[SRC_SR] = i_sr ^ o_maj;
        o_diff[SRC_JK] = i_jk ^ o_maj;
    end
endmodule

// File: rtl/t_decode_chk.sv
// Votes redundant T-flop Q samples, recovers T, counts toggles and flags persistent disagreement.
// Toggle counter is built only when TDEC_TOGGLE_CNT_EN is defined; otherwise toggle_cnt is 0.
module t_decode_chk
    import t_decode_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned FAULT_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_valid,
    input  logic             q_d,
    input  logic             q_sr,
    input  logic             q_jk,
    input  logic             clr_fault,
    output logic             t_out,
    output logic             t_valid,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             mismatch,
    output logic             fault,
    output logic [2:0]       fault_src,
    output logic [1:0]       state
);
    localparam logic [3:0] TH = 4'(FAULT_THRESH);

    logic       w_maj;
    logic       w_disagree;
    logic [2:0] w_diff;
    logic [3:0] w_run_next;

    state_t     r_state;
    logic       r_prev;
    logic [3:0] r_run;
    logic       r_t_out;
    logic       r_t_valid;
    logic       r_mismatch;
    logic       r_fault;
    logic [2:0] r_fault_src;

    maj3_vote u_vote (
        .i_d        (q_d),
        .i_sr       (q_sr),
        .i_jk       (q_jk),
        .o_maj      (w_maj),
        .o_disagree (w_disagree),
        .o_diff     (w_diff)
    );

    always_comb begin
        w_run_next = '0;
        if (w_disagree) begin
            w_run_next = (r_run == TH) ? r_run : r_run + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SYNC;
            r_prev      <= 1'b0;
            r_run       <= '0;
            r_t_out     <= 1'b0;
            r_t_valid   <= 1'b0;
            r_mismatch  <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_src <= '0;
        end else if (clr_fault) begin
            r_state     <= SYNC;
            r_run       <= '0;
            r_t_valid   <= 1'b0;
            r_mismatch  <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_src <= '0;
        end else if (q_valid) begin
            r_mismatch <= w_disagree;
            r_run      <= w_run_next;
            r_prev     <= w_maj;
            case (r_state)
                SYNC: begin
                    r_t_valid <= 1'b0;
                    r_state   <= RUN;
                end
                RUN: begin
                    r_t_out   <= w_maj ^ r_prev;
                    r_t_valid <= 1'b1;
                    // A run seeded during SYNC can only trip the fault from here.
                    if (w_run_next == TH) begin
                        r_state     <= FAULT;
                        r_fault     <= 1'b1;
                        r_fault_src <= w_diff;
                    end
                end
                default: begin
                    r_t_out   <= w_maj ^ r_prev;
                    r_t_valid <= 1'b1;
                end
            endcase
        end else begin
            r_t_valid <= 1'b0;
        end
    end

`ifdef TDEC_TOGGLE_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_fault) begin
            r_cnt <= '0;
        end else if (q_valid && (r_state != SYNC) && (w_maj ^ r_prev) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign toggle_cnt = r_cnt;
`else
    assign toggle_cnt = '0;
`endif

    assign t_out     = r_t_out;
    assign t_valid   = r_t_valid;
    assign mismatch  = r_mismatch;
    assign fault     = r_fault;
    assign fault_src = r_fault_src;
    assign state     = r_state;
endmodule

// File: doc/t_decode_chk.md
# t_decode_chk

Decoder and checker for the T flip-flop family. It takes the three redundant flip-flop outputs (D-based, SR-based, JK-based) and majority-votes them into one Q. It recovers the toggle input T from successive Q samples, counts toggles, and raises a sticky fault when the implementations disagree persistently. It sits on the receive side of a T-flop array and turns a Q stream back into the T stream that produced it.

## Interface
Parameters:
- CNT_W, 8: toggle counter width in bits. Must be ≥ 1.
- FAULT_THRESH, 3: number of consecutive mismatching valid samples that causes a fault. Range 1..15.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- q_valid  in  1  q_d/q_sr/q_jk hold a new sample this cycle.
- q_d  in  1  Q from the D-based T flop.
- q_sr  in  1  Q from the SR-based T flop.
- q_jk  in  1  Q from the JK-based T flop.
- clr_fault  in  1  synchronous clear: fault, counters, restart sync.
- t_out  out  1  recovered T (vote XOR previous vote).
- t_valid  out  1  t_out is valid this cycle.
- toggle_cnt  out  CNT_W  count of recovered T=1 samples, saturating.
- mismatch  out  1  the last valid sample had a disagreement.
- fault  out  1  sticky persistent-disagreement flag.
- fault_src  out  3  disagreeing input at fault entry, one-hot: {q_jk, q_sr, q_d}.
- state  out  2  FSM state: SYNC=0, RUN=1, FAULT=2.

## Operation
- Vote: maj = (q_d&q_sr)|(q_d&q_jk)|(q_sr&q_jk). A sample disagrees when the three inputs are not all equal.
- Reset values: t_out 0, t_valid 0, toggle_cnt 0, mismatch 0, fault 0, fault_src 0, state SYNC. The internal previous-vote register and mismatch-run counter also reset to 0.
- SYNC:
  - On q_valid, store maj as prev and go to RUN.
  - No t_valid is produced, since there is no previous Q to compare against.
  - mismatch is still updated.
- RUN and FAULT, on each q_valid:
  - t_out <= maj ^ prev, t_valid <= 1, prev <= maj.
  - If maj ^ prev, toggle_cnt increments, saturating at 2^CNT_W-1.
- Mismatch run:
  - On a disagreeing valid sample, mismatch <= 1 and run increments, saturating at FAULT_THRESH.
  - On an agreeing valid sample, mismatch <= 0 and run <= 0.
- Fault entry: in RUN, when run reaches FAULT_THRESH, go to FAULT on that same edge.
  - fault <= 1.
  - fault_src <= inputs that differ from maj in that sample.
- FAULT keeps decoding. fault and fault_src hold until clr_fault or rst.
- q_valid low: t_valid <= 0. All other registers hold; the run counter is neither reset nor advanced.
- clr_fault, in any state:
  - Go to SYNC.
  - fault, fault_src, run, mismatch and toggle_cnt <= 0; t_valid <= 0.
  - It has priority over a simultaneous q_valid, and that sample is dropped.
- A disagreement while in SYNC counts toward run and can trigger a fault only after RUN is entered. The SYNC sample seeds run.

## Timing
- Latency: q_valid sample at edge N appears as t_out/t_valid/mismatch after edge N; t_valid is a one-cycle pulse per sample.
- fault asserts after the edge of the FAULT_THRESH-th consecutive mismatching valid sample.
- Back-to-back q_valid every cycle is supported at full rate. There is no backpressure.
- rst asserted mid-stream forces every output to its reset value immediately, without waiting for clk. The first valid sample after release is a SYNC sample.

## Configuration
- TDEC_TOGGLE_CNT_EN defined: the toggle counter is built and operates as described above.
- TDEC_TOGGLE_CNT_EN undefined: no counter flops are built, toggle_cnt is tied to 0, and all other behaviour is unchanged.

## Structure
- Package t_decode_pkg holds:
  - the state enum (SYNC/RUN/FAULT, 2 bits);
  - the fault_src bit-position constants (SRC_D=0, SRC_SR=1, SRC_JK=2).
- Sub-module maj3_vote: combinational. Outputs maj, a disagree flag, and a 3-bit one-hot of which inputs differ from maj.

## Test plan
- Reset, then valid Q samples all-equal 0,1,1,0,1 on consecutive cycles -> t_out = 1,0,1,1 with t_valid for 4 cycles, toggle_cnt=3, state RUN, fault=0.
- In RUN, one sample with q_d=0, q_sr=0, q_jk=1 -> mismatch=1 for that sample, vote 0, t_out reflects 0, next agreeing sample clears mismatch, fault=0.
- q_sr inverted on 3 consecutive valid samples (FAULT_THRESH=3) -> fault=1 after the third edge, state=2, fault_src=3'b010. Decoding continues afterwards.
- Same as the previous case but with q_valid low for 2 cycles between mismatches -> fault still asserts on the third mismatching valid sample.
- clr_fault together with q_valid in FAULT -> next cycle fault=0, fault_src=0, toggle_cnt=0, state SYNC, t_valid=0. The following valid sample produces no t_valid.
- CNT_W=2 with 5 toggles -> toggle_cnt saturates at 3. Async rst pulsed between clock edges -> all outputs 0 before the next edge.
